// File: rtl/io1_ram_sequencer.sv
// IO1 SRAM window sequencer: turns synchronised PHI2/IO1 accesses into timed SRAM strobes,
// with an IO2 page/status register file supplying address_mem[18:8].
//
// state  | meaning
// IDLE   | waiting for a synced PHI2 rise with IO1 or IO2 selected
// SETUP  | _ce_ram low, address (and write data) settling
// STROBE | _we_mem low on writes, read data settling on reads
// HOLD   | strobes released, read data driven to CPU until PHI2 falls
module io1_ram_sequencer #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 3
) (
  input  logic        clock_mult,
  input  logic        reset_cpu,
  input  logic        clock_cpu,
  input  logic        r_w_cpu,
  input  logic [2:1]  _io,
  input  logic [15:0] address_cpu,
  input  logic [7:0]  data_cpu_in,
  output logic [7:0]  data_cpu_out,
  output logic        data_cpu_oe,
  output logic [18:0] address_mem,
  input  logic [7:0]  data_mem_in,
  output logic [7:0]  data_mem_out,
  output logic        data_mem_oe,
  output logic        _we_mem,
  output logic        _ce_ram
);

  localparam int CW = 8;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            rw_l;
  logic            reg_acc;
  logic [7:0]      addr_l;
  logic [10:0]     page;
  logic            overrun;

  logic [19:0]     sync1, sync2;
  logic            phi_prev;
  logic            phi_s, rw_s, rise, fall;
  logic [2:1]      io_s;
  logic [7:0]      addr_s, data_s;
  logic            unused_addr_hi;

  assign unused_addr_hi = &{1'b0, address_cpu[15:8]};

  // The pipeline keeps running through reset so a reset while PHI2 is high
  // cannot manufacture a false rise afterwards.
  always_ff @(posedge clock_mult) begin
    sync1    <= {clock_cpu, r_w_cpu, _io, address_cpu[7:0], data_cpu_in};
    sync2    <= sync1;
    phi_prev <= sync2[19];
  end

  assign phi_s  = sync2[19];
  assign rw_s   = sync2[18];
  assign io_s   = sync2[17:16];
  assign addr_s = sync2[15:8];
  assign data_s = sync2[7:0];
  assign rise   = phi_s & ~phi_prev;
  assign fall   = ~phi_s & phi_prev;

  always_ff @(posedge clock_mult) begin
    if (reset_cpu) begin
      state        <= IDLE;
      cnt          <= '0;
      rw_l         <= 1'b1;
      reg_acc      <= 1'b0;
      addr_l       <= '0;
      page         <= '0;
      overrun      <= 1'b0;
      data_cpu_out <= '0;
      data_cpu_oe  <= 1'b0;
      address_mem  <= '0;
      data_mem_out <= '0;
      data_mem_oe  <= 1'b0;
      _we_mem      <= 1'b1;
      _ce_ram      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rise && !io_s[1]) begin
            rw_l        <= rw_s;
            addr_l      <= addr_s;
            reg_acc     <= 1'b0;
            address_mem <= {page, addr_s};
            _ce_ram     <= 1'b0;
            data_mem_oe <= ~rw_s;
            if (!rw_s) data_mem_out <= data_s;
            cnt         <= CW'(SETUP_CYCLES - 1);
            state       <= SETUP;
          end else if (rise && !io_s[2]) begin
            rw_l    <= rw_s;
            addr_l  <= addr_s;
            reg_acc <= 1'b1;
            if (rw_s) begin
              case (addr_s)
                8'h00: begin data_cpu_out <= page[7:0];              data_cpu_oe <= 1'b1; end
                8'h01: begin data_cpu_out <= {5'b0, page[10:8]};     data_cpu_oe <= 1'b1; end
                8'h02: begin data_cpu_out <= {7'b0, overrun};        data_cpu_oe <= 1'b1; end
                default: data_cpu_oe <= 1'b0;
              endcase
            end
            state <= HOLD;
          end
        end
        SETUP, STROBE: begin
          // PHI2 ended before the access completed: drop everything, flag it.
          if (fall) begin
            _ce_ram     <= 1'b1;
            _we_mem     <= 1'b1;
            data_mem_oe <= 1'b0;
            data_cpu_oe <= 1'b0;
            overrun     <= 1'b1;
            state       <= IDLE;
          end else if (state == SETUP) begin
            if (!rw_l) data_mem_out <= data_s;
            if (cnt == '0) begin
              cnt     <= CW'(STROBE_CYCLES - 1);
              _we_mem <= rw_l;
              state   <= STROBE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end else if (cnt == '0) begin
            _we_mem     <= 1'b1;
            _ce_ram     <= 1'b1;
            data_mem_oe <= 1'b0;
            if (rw_l) begin
              data_cpu_out <= data_mem_in;
              data_cpu_oe  <= 1'b1;
            end
            state <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (fall) begin
            data_cpu_oe <= 1'b0;
            state       <= IDLE;
            if (reg_acc && !rw_l) begin
              case (addr_l)
                8'h00:   page[7:0]  <= data_s;
                8'h01:   page[10:8] <= data_s[2:0];
                8'h02:   overrun    <= 1'b0;
                default: ;
              endcase
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io1_ram_sequencer.sv
// Bench for io1_ram_sequencer: directed vector table, reset-in-strobe sequence,
// then random bus cycles against a transaction-level model of the window and registers.
module tb_io1_ram_sequencer;

  localparam int SC = 1;
  localparam int TC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        phi = 1'b0;
  logic        rw = 1'b1;
  logic [2:1]  io_n = 2'b11;
  logic [15:0] acpu = '0;
  logic [7:0]  dcpu = '0;
  logic [7:0]  dout;
  logic        doe;
  logic [18:0] amem;
  logic [7:0]  dmem_in;
  logic [7:0]  dmem_out;
  logic        dmem_oe;
  logic        we_n;
  logic        ce_n;

  always #5 clk = ~clk;

  io1_ram_sequencer #(.SETUP_CYCLES(SC), .STROBE_CYCLES(TC)) dut (
    .clock_mult(clk), .reset_cpu(rst), .clock_cpu(phi), .r_w_cpu(rw), ._io(io_n),
    .address_cpu(acpu), .data_cpu_in(dcpu), .data_cpu_out(dout), .data_cpu_oe(doe),
    .address_mem(amem), .data_mem_in(dmem_in), .data_mem_out(dmem_out),
    .data_mem_oe(dmem_oe), ._we_mem(we_n), ._ce_ram(ce_n)
  );

  // SRAM on the memory bus
  logic [7:0]  sram [0:524287];
  logic        pre_en = 1'b0;
  logic [18:0] pre_a = '0;
  logic [7:0]  pre_d = '0;
  assign dmem_in = sram[amem];
  always @(posedge clk) begin
    if (pre_en) sram[pre_a] <= pre_d;
    else if (!we_n && !ce_n && dmem_oe) sram[amem] <= dmem_out;
  end

  typedef struct {
    int ce; int we; int oe; int moe; int first_ce; int first_oe;
    logic [18:0] addr; logic addr_var;
    logic [7:0] wd; logic wd_var;
    logic [7:0] rd; logic rd_var;
  } stats_t;

  typedef struct {
    int ce; int we; int oe; int moe; int first_oe;
    logic [18:0] addr; logic [7:0] wd; logic [7:0] rd; logic rd_known;
  } exp_t;

  typedef struct {
    logic [1:0] io; logic rw; logic [7:0] a; logic [7:0] d; int hi;
    int e_ce; int e_we; int e_oe; logic [18:0] e_addr; logic [7:0] e_wd; logic [7:0] e_rd;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [10:0] mdl_page = '0;
  logic        mdl_ovr = 1'b0;
  logic [7:0]  mdl_mem [logic [18:0]];

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // io is {_io[2], _io[1]}; one full PHI2 period, sampled every clock after the edge
  task automatic run_txn(input logic [1:0] io, input logic r, input logic [7:0] a,
                         input logic [7:0] d, input int hi, input int lo, output stats_t st);
    st = '{first_ce: -1, first_oe: -1, default: 0};
    for (int i = 0; i < hi + lo + 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        io_n = io; rw = r; dcpu = d; phi = 1'b1;
        acpu = {(io[0] ? 8'hDF : 8'hDE), a};
      end
      if (i == hi) phi = 1'b0;
      if (i == hi + lo) io_n = 2'b11;
      @(posedge clk); #1;
      if (!ce_n) begin
        if (st.ce == 0) begin st.first_ce = i; st.addr = amem; end
        else if (amem !== st.addr) st.addr_var = 1'b1;
        st.ce++;
      end
      if (!we_n) begin
        if (st.we == 0) st.wd = dmem_out;
        else if (dmem_out !== st.wd) st.wd_var = 1'b1;
        st.we++;
      end
      if (doe) begin
        if (st.oe == 0) begin st.first_oe = i; st.rd = dout; end
        else if (dout !== st.rd) st.rd_var = 1'b1;
        st.oe++;
      end
      if (dmem_oe) st.moe++;
    end
  endtask

  // Transaction-level effect of one bus cycle whose PHI2 is high for hi clocks
  task automatic model_apply(input logic [1:0] io, input logic r, input logic [7:0] a,
                             input logic [7:0] d, input int hi, output exp_t e);
    int n;
    n = SC + TC;
    e = '{default: 0};
    if (!io[0]) begin
      e.addr = {mdl_page, a};
      e.ce = (hi < n) ? hi : n;
      e.we = r ? 0 : e.ce - SC;
      e.moe = r ? 0 : e.ce;
      e.oe = (r && hi > n) ? hi - n : 0;
      e.first_oe = 2 + n;
      e.wd = d;
      if (r && mdl_mem.exists(e.addr)) begin e.rd = mdl_mem[e.addr]; e.rd_known = 1'b1; end
      if (!r && e.we > 0) mdl_mem[e.addr] = d;
      if (hi <= n) mdl_ovr = 1'b1;
    end else if (!io[1]) begin
      e.first_oe = 2;
      if (r) begin
        if (a <= 8'd2) begin
          e.oe = hi;
          e.rd_known = 1'b1;
          e.rd = (a == 8'd0) ? mdl_page[7:0] : (a == 8'd1) ? {5'b0, mdl_page[10:8]} : {7'b0, mdl_ovr};
        end
      end else begin
        if (a == 8'd0) mdl_page[7:0] = d;
        else if (a == 8'd1) mdl_page[10:8] = d[2:0];
        else if (a == 8'd2) mdl_ovr = 1'b0;
      end
    end
  endtask

  task automatic compare_txn(input string tag, input stats_t st, input exp_t e);
    check({tag, " ce_low"}, st.ce, e.ce);
    check({tag, " we_low"}, st.we, e.we);
    check({tag, " cpu_oe"}, st.oe, e.oe);
    check({tag, " mem_oe"}, st.moe, e.moe);
    if (e.ce > 0) begin
      check({tag, " ce_start"}, st.first_ce, 2);
      check({tag, " addr"}, int'(st.addr), int'(e.addr));
      check({tag, " addr_stable"}, int'(st.addr_var), 0);
    end
    if (e.we > 0) begin
      check({tag, " wdata"}, int'(st.wd), int'(e.wd));
      check({tag, " wdata_stable"}, int'(st.wd_var), 0);
    end
    if (e.oe > 0) begin
      check({tag, " oe_start"}, st.first_oe, e.first_oe);
      if (e.rd_known) begin
        check({tag, " rdata"}, int'(st.rd), int'(e.rd));
        check({tag, " rdata_stable"}, int'(st.rd_var), 0);
      end
    end
  endtask

  initial begin
    vec_t   tbl[$];
    stats_t st;
    exp_t   e, e_dummy;
    logic   seen;
    int     ce_after;

    tbl.push_back('{2'b10, 1'b0, 8'h34, 8'hA5, 8, 4, 3, 0, 19'h00034, 8'hA5, 8'h00});
    tbl.push_back('{2'b01, 1'b0, 8'h00, 8'h12, 8, 0, 0, 0, 19'h0, 8'h0, 8'h00});
    tbl.push_back('{2'b01, 1'b0, 8'h01, 8'h05, 8, 0, 0, 0, 19'h0, 8'h0, 8'h00});
    tbl.push_back('{2'b10, 1'b1, 8'hFF, 8'h00, 8, 4, 0, 4, 19'h512FF, 8'h0, 8'h3C});
    tbl.push_back('{2'b01, 1'b1, 8'h01, 8'h00, 8, 0, 0, 8, 19'h0, 8'h0, 8'h05});
    tbl.push_back('{2'b01, 1'b1, 8'h00, 8'h00, 8, 0, 0, 8, 19'h0, 8'h0, 8'h12});
    tbl.push_back('{2'b10, 1'b0, 8'h10, 8'h77, 3, 3, 2, 0, 19'h51210, 8'h77, 8'h00});
    tbl.push_back('{2'b01, 1'b1, 8'h02, 8'h00, 8, 0, 0, 8, 19'h0, 8'h0, 8'h01});
    tbl.push_back('{2'b01, 1'b0, 8'h02, 8'h5A, 8, 0, 0, 0, 19'h0, 8'h0, 8'h00});
    tbl.push_back('{2'b01, 1'b1, 8'h02, 8'h00, 8, 0, 0, 8, 19'h0, 8'h0, 8'h00});
    tbl.push_back('{2'b00, 1'b0, 8'h00, 8'h99, 8, 4, 3, 0, 19'h51200, 8'h99, 8'h00});
    tbl.push_back('{2'b01, 1'b1, 8'h00, 8'h00, 8, 0, 0, 8, 19'h0, 8'h0, 8'h12});
    tbl.push_back('{2'b01, 1'b1, 8'h07, 8'h00, 8, 0, 0, 0, 19'h0, 8'h0, 8'h00});
    tbl.push_back('{2'b11, 1'b0, 8'h00, 8'h44, 8, 0, 0, 0, 19'h0, 8'h0, 8'h00});
    tbl.push_back('{2'b01, 1'b1, 8'h00, 8'h00, 8, 0, 0, 8, 19'h0, 8'h0, 8'h12});
    tbl.push_back('{2'b01, 1'b0, 8'h01, 8'hFF, 8, 0, 0, 0, 19'h0, 8'h0, 8'h00});
    tbl.push_back('{2'b01, 1'b1, 8'h01, 8'h00, 8, 0, 0, 8, 19'h0, 8'h0, 8'h07});
    tbl.push_back('{2'b10, 1'b0, 8'h00, 8'hC3, 8, 4, 3, 0, 19'h71200, 8'hC3, 8'h00});
    tbl.push_back('{2'b10, 1'b1, 8'h00, 8'h00, 6, 4, 0, 2, 19'h71200, 8'h0, 8'hC3});
    tbl.push_back('{2'b10, 1'b1, 8'h00, 8'h00, 4, 4, 0, 0, 19'h71200, 8'h0, 8'h00});
    tbl.push_back('{2'b01, 1'b1, 8'h02, 8'h00, 8, 0, 0, 8, 19'h0, 8'h0, 8'h01});
    tbl.push_back('{2'b01, 1'b0, 8'h02, 8'h00, 8, 0, 0, 0, 19'h0, 8'h0, 8'h00});
    tbl.push_back('{2'b01, 1'b1, 8'h02, 8'h00, 5, 0, 0, 5, 19'h0, 8'h0, 8'h00});

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset we_n", int'(we_n), 1);
    check("reset ce_n", int'(ce_n), 1);
    check("reset cpu_oe", int'(doe), 0);
    check("reset mem_oe", int'(dmem_oe), 0);
    check("reset cpu_out", int'(dout), 0);
    check("reset mem_out", int'(dmem_out), 0);
    check("reset addr", int'(amem), 0);
    @(negedge clk);
    rst = 1'b0;
    pre_en = 1'b1; pre_a = 19'h512FF; pre_d = 8'h3C;
    @(negedge clk);
    pre_en = 1'b0;
    mdl_mem[19'h512FF] = 8'h3C;
    repeat (3) @(negedge clk);

    foreach (tbl[k]) begin
      exp_t ev;
      model_apply(tbl[k].io, tbl[k].rw, tbl[k].a, tbl[k].d, tbl[k].hi, e_dummy);
      run_txn(tbl[k].io, tbl[k].rw, tbl[k].a, tbl[k].d, tbl[k].hi, 4, st);
      ev.ce = tbl[k].e_ce; ev.we = tbl[k].e_we; ev.oe = tbl[k].e_oe;
      ev.moe = tbl[k].rw ? 0 : tbl[k].e_ce;
      ev.first_oe = tbl[k].io[0] ? 2 : 2 + SC + TC;
      ev.addr = tbl[k].e_addr; ev.wd = tbl[k].e_wd; ev.rd = tbl[k].e_rd; ev.rd_known = 1'b1;
      compare_txn($sformatf("vec%0d", k), st, ev);
    end

    // reset asserted while a write is strobing (page is nonzero here)
    @(negedge clk);
    io_n = 2'b10; rw = 1'b0; acpu = 16'hDE55; dcpu = 8'hE1; phi = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(posedge clk); #1;
      if (!we_n) seen = 1'b1;
    end
    check("rst_seq strobe_reached", int'(seen), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_seq we_n", int'(we_n), 1);
    check("rst_seq ce_n", int'(ce_n), 1);
    check("rst_seq cpu_oe", int'(doe), 0);
    check("rst_seq mem_oe", int'(dmem_oe), 0);
    check("rst_seq addr", int'(amem), 0);
    @(posedge clk); #1;
    check("rst_seq we_n_2nd", int'(we_n), 1);
    @(negedge clk);
    rst = 1'b0;
    ce_after = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 3) phi = 1'b0;
      if (k == 7) io_n = 2'b11;
      @(posedge clk); #1;
      if (!ce_n) ce_after++;
    end
    check("rst_seq no_restart", ce_after, 0);
    mdl_mem[19'h71255] = 8'hE1;
    mdl_page = '0;
    mdl_ovr = 1'b0;

    for (int t = 0; t < 160; t++) begin
      logic [1:0] io;
      logic       r;
      logic [7:0] a, d;
      int         hi, lo, kind;
      kind = $urandom_range(0, 9);
      io = (kind < 4) ? 2'b10 : (kind < 8) ? 2'b01 : (kind == 8) ? 2'b00 : 2'b11;
      r  = 1'($urandom_range(0, 1));
      if (io[0]) begin
        a = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 2));
        d = (a < 8'd2) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      end else begin
        a = 8'($urandom_range(0, 7));
        d = 8'($urandom);
      end
      hi = $urandom_range(3, 9);
      lo = $urandom_range(3, 6);
      model_apply(io, r, a, d, hi, e);
      run_txn(io, r, a, d, hi, lo, st);
      compare_txn($sformatf("rnd%0d", t), st, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
